// File: rtl/pcileech_cfg_pkg.sv
// Shared types and helpers for the cfg_mgmt RW1C clearing sequencer.
// Holds the sequencer states, the response status codes and the byte-enable helper.
package pcileech_cfg_pkg;

   // The two gap states keep one idle cycle between consecutive cfg_mgmt accesses.
   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_GAP_WR,
      S_WR,
      S_GAP_POST,
      S_VRD,
      S_RESP
   } state_t;

   localparam logic [1:0] ST_OK          = 2'd0;
   localparam logic [1:0] ST_NOOP        = 2'd1;
   localparam logic [1:0] ST_TIMEOUT     = 2'd2;
   localparam logic [1:0] ST_VERIFY_FAIL = 2'd3;

   // A byte is written only if it carries at least one bit to clear.
   function automatic logic [3:0] byte_en_of(input logic [31:0] data);
      logic [3:0] be;
      for (int i = 0; i < 4; i++) begin
         be[i] = |data[8*i +: 8];
      end
      return be;
   endfunction

endpackage

// File: rtl/pcileech_cfg_access_timer.sv
// Per-access watchdog: counts cycles spent waiting for cfg_mgmt_rd_wr_done.
// expire fires in the last permitted cycle so the strobe is held exactly TIMEOUT_CYCLES cycles.
module pcileech_cfg_access_timer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   // Saturates at the limit so a stalled tick can never wrap back into range.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (tick && count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   assign expire = tick && (count == TERMINAL);

endmodule

// File: rtl/pcileech_cfg_rw1c_clearer.sv
// Clears RW1C status bits in the PCIe core config space: read, write back set&mask bits, optional verify.
// cfg_mgmt_wr_rw1c_as_rw is held low so the core applies genuine write-1-to-clear semantics.
module pcileech_cfg_rw1c_clearer
   import pcileech_cfg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [9:0]  req_dwaddr,
   input  logic [31:0] req_mask,
   input  logic        req_verify,
   output logic        rsp_valid,
   output logic [1:0]  rsp_status,
   output logic [31:0] rsp_cleared,
   output logic [31:0] rsp_residual,
   output logic [9:0]  cfg_mgmt_dwaddr,
   output logic [31:0] cfg_mgmt_di,
   output logic [3:0]  cfg_mgmt_byte_en,
   output logic        cfg_mgmt_wr_en,
   output logic        cfg_mgmt_rd_en,
   output logic        cfg_mgmt_wr_readonly,
   output logic        cfg_mgmt_wr_rw1c_as_rw,
   input  logic [31:0] cfg_mgmt_do,
   input  logic        cfg_mgmt_rd_wr_done
);

   state_t      state;
   state_t      next_state;
   logic [9:0]  addr_q;
   logic [31:0] mask_q;
   logic        verify_q;
   logic [31:0] clear_q;
   logic [1:0]  next_status;
   logic [31:0] next_cleared;
   logic [31:0] next_residual;
   logic [31:0] rd_masked;
   logic        in_access;
   logic        timer_tick;
   logic        timer_expire;

   assign rd_masked = cfg_mgmt_do & mask_q;
   assign in_access = (state == S_RD) || (state == S_WR) || (state == S_VRD);

   pcileech_cfg_access_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (!in_access),
      .tick  (timer_tick),
      .expire(timer_expire)
   );

   // Next-state and response selection; done wins over the terminal count.
   always_comb begin
      next_state    = state;
      next_status   = ST_OK;
      next_cleared  = clear_q;
      next_residual = '0;
      timer_tick    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req_valid) begin
               next_state = S_RD;
            end
         end
         S_RD: begin
            timer_tick = !cfg_mgmt_rd_wr_done;
            if (cfg_mgmt_rd_wr_done) begin
               if (rd_masked == '0) begin
                  next_state   = S_RESP;
                  next_status  = ST_NOOP;
                  next_cleared = '0;
               end else begin
                  next_state = S_GAP_WR;
               end
            end else if (timer_expire) begin
               next_state   = S_RESP;
               next_status  = ST_TIMEOUT;
               next_cleared = '0;
            end
         end
         S_GAP_WR: begin
            next_state = S_WR;
         end
         S_WR: begin
            timer_tick = !cfg_mgmt_rd_wr_done;
            if (cfg_mgmt_rd_wr_done) begin
               next_state = S_GAP_POST;
            end else if (timer_expire) begin
               next_state  = S_RESP;
               next_status = ST_TIMEOUT;
            end
         end
         S_GAP_POST: begin
            next_state = verify_q ? S_VRD : S_RESP;
         end
         S_VRD: begin
            timer_tick = !cfg_mgmt_rd_wr_done;
            if (cfg_mgmt_rd_wr_done) begin
               next_state    = S_RESP;
               next_residual = rd_masked;
               next_status   = ((rd_masked & clear_q) != '0) ? ST_VERIFY_FAIL : ST_OK;
            end else if (timer_expire) begin
               next_state  = S_RESP;
               next_status = ST_TIMEOUT;
            end
         end
         S_RESP: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Request fields are latched once at acceptance; response fields only change on entry to RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         addr_q       <= '0;
         mask_q       <= '0;
         verify_q     <= 1'b0;
         clear_q      <= '0;
         rsp_status   <= ST_OK;
         rsp_cleared  <= '0;
         rsp_residual <= '0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && req_valid) begin
            addr_q   <= req_dwaddr;
            mask_q   <= req_mask;
            verify_q <= req_verify;
            clear_q  <= '0;
         end
         if (state == S_RD && cfg_mgmt_rd_wr_done) begin
            clear_q <= rd_masked;
         end
         if (next_state == S_RESP) begin
            rsp_status   <= next_status;
            rsp_cleared  <= next_cleared;
            rsp_residual <= next_residual;
         end
      end
   end

   assign req_ready              = (state == S_IDLE);
   assign rsp_valid              = (state == S_RESP);
   assign cfg_mgmt_dwaddr        = addr_q;
   assign cfg_mgmt_rd_en         = (state == S_RD) || (state == S_VRD);
   assign cfg_mgmt_wr_en         = (state == S_WR);
   assign cfg_mgmt_di            = (state == S_WR) ? clear_q : '0;
   assign cfg_mgmt_byte_en       = (state == S_WR) ? byte_en_of(clear_q) : 4'b0000;
   assign cfg_mgmt_wr_readonly   = 1'b0;
   assign cfg_mgmt_wr_rw1c_as_rw = 1'b0;

endmodule

// File: tb/tb_pcileech_cfg_rw1c_clearer.sv
// Bench for the RW1C clearer: table-driven requests against a simple cfg_mgmt responder model.
// Expected responses are queued at issue time and compared when rsp_valid pulses.
module tb_pcileech_cfg_rw1c_clearer;
   import pcileech_cfg_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [9:0]  req_dwaddr;
   logic [31:0] req_mask;
   logic        req_verify;
   logic        rsp_valid;
   logic [1:0]  rsp_status;
   logic [31:0] rsp_cleared;
   logic [31:0] rsp_residual;
   logic [9:0]  cfg_mgmt_dwaddr;
   logic [31:0] cfg_mgmt_di;
   logic [3:0]  cfg_mgmt_byte_en;
   logic        cfg_mgmt_wr_en;
   logic        cfg_mgmt_rd_en;
   logic        cfg_mgmt_wr_readonly;
   logic        cfg_mgmt_wr_rw1c_as_rw;
   logic [31:0] cfg_mgmt_do;
   logic        cfg_mgmt_rd_wr_done;

   always #5 clk = ~clk;

   pcileech_cfg_rw1c_clearer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .req_valid             (req_valid),
      .req_ready             (req_ready),
      .req_dwaddr            (req_dwaddr),
      .req_mask              (req_mask),
      .req_verify            (req_verify),
      .rsp_valid             (rsp_valid),
      .rsp_status            (rsp_status),
      .rsp_cleared           (rsp_cleared),
      .rsp_residual          (rsp_residual),
      .cfg_mgmt_dwaddr       (cfg_mgmt_dwaddr),
      .cfg_mgmt_di           (cfg_mgmt_di),
      .cfg_mgmt_byte_en      (cfg_mgmt_byte_en),
      .cfg_mgmt_wr_en        (cfg_mgmt_wr_en),
      .cfg_mgmt_rd_en        (cfg_mgmt_rd_en),
      .cfg_mgmt_wr_readonly  (cfg_mgmt_wr_readonly),
      .cfg_mgmt_wr_rw1c_as_rw(cfg_mgmt_wr_rw1c_as_rw),
      .cfg_mgmt_do           (cfg_mgmt_do),
      .cfg_mgmt_rd_wr_done   (cfg_mgmt_rd_wr_done)
   );

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] mask;
      logic        verify;
      logic [31:0] rd_data;
      logic [31:0] vrd_data;
      int          rd_dly;
      int          wr_dly;
      int          vrd_dly;
      logic [1:0]  status;
      logic [31:0] cleared;
      logic [31:0] residual;
      int          rd_cyc;
      int          wr_cyc;
      logic [31:0] di;
      logic [3:0]  be;
   } vec_t;

   typedef struct {
      logic [1:0]  status;
      logic [31:0] cleared;
      logic [31:0] residual;
      int          rd_cyc;
      int          wr_cyc;
      logic [31:0] di;
      logic [3:0]  be;
      logic [9:0]  addr;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[10];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic exp_t toExp(input vec_t v);
      exp_t e;
      e.status   = v.status;
      e.cleared  = v.cleared;
      e.residual = v.residual;
      e.rd_cyc   = v.rd_cyc;
      e.wr_cyc   = v.wr_cyc;
      e.di       = v.di;
      e.be       = v.be;
      e.addr     = v.addr;
      return e;
   endfunction

   // Responder model: done after a per-access number of strobe cycles (0 = never).
   logic [31:0] r_rd_data, r_vrd_data;
   int          r_rd_dly, r_wr_dly, r_vrd_dly;
   int          read_idx;
   logic        stray;

   initial begin
      int hi;
      int dly;
      hi = 0;
      cfg_mgmt_rd_wr_done = 1'b0;
      cfg_mgmt_do = '0;
      forever begin
         @(negedge clk);
         cfg_mgmt_rd_wr_done = 1'b0;
         cfg_mgmt_do = '0;
         if (rst) begin
            hi = 0;
         end else if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
            hi++;
            dly = cfg_mgmt_wr_en ? r_wr_dly : ((read_idx == 0) ? r_rd_dly : r_vrd_dly);
            if (dly != 0 && hi == dly) begin
               cfg_mgmt_rd_wr_done = 1'b1;
               if (cfg_mgmt_rd_en) begin
                  cfg_mgmt_do = (read_idx == 0) ? r_rd_data : r_vrd_data;
                  read_idx++;
               end
            end
         end else begin
            hi = 0;
            if (stray) begin
               cfg_mgmt_rd_wr_done = 1'b1;
               cfg_mgmt_do = 32'hFFFF_FFFF;
            end
         end
      end
   end

   // Monitor: per-response access statistics and scoreboard comparison.
   int          mon_rd, mon_wr, overlap;
   logic [31:0] mon_di;
   logic [3:0]  mon_be;
   logic [9:0]  mon_addr;
   int          first_rd_cyc, first_wr_cyc;

   initial begin
      exp_t e;
      mon_rd = 0; mon_wr = 0; overlap = 0; mon_di = '0; mon_be = '0; mon_addr = '0;
      first_rd_cyc = -1; first_wr_cyc = -1;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_rd = 0; mon_wr = 0; mon_di = '0; mon_be = '0; mon_addr = '0;
         end else begin
            if (cfg_mgmt_rd_en && cfg_mgmt_wr_en) overlap++;
            if (cfg_mgmt_rd_en) begin
               if (mon_rd == 0) mon_addr = cfg_mgmt_dwaddr;
               mon_rd++;
               if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (cfg_mgmt_wr_en) begin
               mon_wr++;
               mon_di = cfg_mgmt_di;
               mon_be = cfg_mgmt_byte_en;
               if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
            if (rsp_valid) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 expected 0");
               end else begin
                  e = sb.pop_front();
                  checkOutput("rsp_status", 32'(rsp_status), 32'(e.status));
                  checkOutput("rsp_cleared", rsp_cleared, e.cleared);
                  checkOutput("rsp_residual", rsp_residual, e.residual);
                  checkOutput("rd_cycles", 32'(mon_rd), 32'(e.rd_cyc));
                  checkOutput("wr_cycles", 32'(mon_wr), 32'(e.wr_cyc));
                  checkOutput("wr_di", mon_di, e.di);
                  checkOutput("wr_byte_en", 32'(mon_be), 32'(e.be));
                  checkOutput("rd_dwaddr", 32'(mon_addr), 32'(e.addr));
               end
               mon_rd = 0; mon_wr = 0; mon_di = '0; mon_be = '0; mon_addr = '0;
            end
         end
      end
   end

   task automatic loadResponder(input vec_t v);
      r_rd_data  = v.rd_data;
      r_vrd_data = v.vrd_data;
      r_rd_dly   = v.rd_dly;
      r_wr_dly   = v.wr_dly;
      r_vrd_dly  = v.vrd_dly;
      read_idx   = 0;
   endtask

   task automatic waitRsp(input string name, output int rsp_c);
      int i;
      rsp_c = -1;
      for (i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
      if (rsp_valid) begin
         rsp_c = cyc;
      end else begin
         tests++;
         fails++;
         $display("[TB] FAIL %s_timeout: got no rsp_valid expected rsp_valid=1", name);
         sb.delete();
      end
   endtask

   // Issue one request, scramble the request inputs after acceptance, wait for the response.
   task automatic applyStimulus(input vec_t v, output int acc, output int rsp_c);
      @(negedge clk);
      loadResponder(v);
      first_rd_cyc = -1;
      first_wr_cyc = -1;
      sb.push_back(toExp(v));
      req_dwaddr = v.addr;
      req_mask   = v.mask;
      req_verify = v.verify;
      req_valid  = 1'b1;
      acc = cyc;
      @(negedge clk);
      req_valid  = 1'b0;
      req_dwaddr = ~v.addr;
      req_mask   = ~v.mask;
      req_verify = ~v.verify;
      waitRsp("rsp", rsp_c);
      @(negedge clk);
      checkOutput("ready_after_resp", 32'(req_ready), 32'd1);
   endtask

   initial begin
      int acc, rsp_c, viol, seen;
      vec_t bb;

      vecs[0] = '{10'h004, 32'h0000_F900, 1'b0, 32'h0010_0900, 32'h0, 2, 2, 0,
                  ST_OK, 32'h0000_0900, 32'h0, 2, 2, 32'h0000_0900, 4'b0010};
      vecs[1] = '{10'h005, 32'hFF00_0000, 1'b0, 32'h00FF_FFFF, 32'h0, 2, 2, 0,
                  ST_NOOP, 32'h0, 32'h0, 2, 0, 32'h0, 4'b0000};
      vecs[2] = '{10'h006, 32'h0000_0001, 1'b1, 32'h0000_0001, 32'h0000_0001, 2, 2, 2,
                  ST_VERIFY_FAIL, 32'h1, 32'h1, 4, 2, 32'h1, 4'b0001};
      vecs[3] = '{10'h007, 32'h0000_0101, 1'b1, 32'h0000_0001, 32'h0000_0100, 2, 2, 2,
                  ST_OK, 32'h1, 32'h100, 4, 2, 32'h1, 4'b0001};
      vecs[4] = '{10'h3FF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0081, 32'h0, 3, 1, 0,
                  ST_OK, 32'h8000_0081, 32'h0, 3, 1, 32'h8000_0081, 4'b1001};
      vecs[5] = '{10'h010, 32'h00FF_0000, 1'b0, 32'h0012_3456, 32'h0, 2, 0, 0,
                  ST_TIMEOUT, 32'h0012_0000, 32'h0, 2, 8, 32'h0012_0000, 4'b0100};
      vecs[6] = '{10'h011, 32'h0000_FFFF, 1'b0, 32'h0000_FFFF, 32'h0, 0, 2, 0,
                  ST_TIMEOUT, 32'h0, 32'h0, 8, 0, 32'h0, 4'b0000};
      vecs[7] = '{10'h012, 32'h0000_000F, 1'b0, 32'h0000_0005, 32'h0, 2, 8, 0,
                  ST_OK, 32'h5, 32'h0, 2, 8, 32'h5, 4'b0001};
      vecs[8] = '{10'h013, 32'h0F00_0000, 1'b1, 32'h0300_0000, 32'h0, 2, 2, 0,
                  ST_TIMEOUT, 32'h0300_0000, 32'h0, 10, 2, 32'h0300_0000, 4'b1000};
      vecs[9] = '{10'h014, 32'h0F00_0000, 1'b1, 32'h0300_0000, 32'h0C00_0000, 2, 2, 8,
                  ST_OK, 32'h0300_0000, 32'h0C00_0000, 10, 2, 32'h0300_0000, 4'b1000};

      stray = 1'b0;
      loadResponder(vecs[0]);
      rst = 1'b1;
      req_valid = 1'b0;
      req_dwaddr = '0;
      req_mask = '0;
      req_verify = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_strobes", 32'({cfg_mgmt_rd_en, cfg_mgmt_wr_en, rsp_valid}), 32'd0);
      checkOutput("reset_rsp", 32'(rsp_status) | rsp_cleared | rsp_residual, 32'd0);
      checkOutput("reset_cfg", 32'(cfg_mgmt_dwaddr) | cfg_mgmt_di | 32'(cfg_mgmt_byte_en), 32'd0);
      checkOutput("tied_low", 32'({cfg_mgmt_wr_readonly, cfg_mgmt_wr_rw1c_as_rw}), 32'd0);
      rst = 1'b0;

      $display("[TB] latency check");
      applyStimulus(vecs[0], acc, rsp_c);
      checkOutput("lat_rd_start", 32'(first_rd_cyc - acc), 32'd1);
      checkOutput("lat_wr_start", 32'(first_wr_cyc - acc), 32'd4);
      checkOutput("lat_rsp", 32'(rsp_c - acc), 32'd7);

      $display("[TB] vector table");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i], acc, rsp_c);
      end

      $display("[TB] stray done in idle");
      @(negedge clk);
      stray = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("stray_idle", 32'({rsp_valid, cfg_mgmt_rd_en, cfg_mgmt_wr_en, req_ready}), 32'b0001);
      end
      stray = 1'b0;
      applyStimulus(vecs[0], acc, rsp_c);

      $display("[TB] reset mid read");
      @(negedge clk);
      bb = vecs[6];
      loadResponder(bb);
      req_dwaddr = bb.addr;
      req_mask = bb.mask;
      req_verify = 1'b0;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("mid_rd_strobe", 32'(cfg_mgmt_rd_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_rd_en", 32'(cfg_mgmt_rd_en), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      checkOutput("rst_no_rsp", 32'(seen), 32'd0);

      $display("[TB] back to back");
      @(negedge clk);
      bb = vecs[0];
      bb.vrd_data = bb.rd_data;
      bb.vrd_dly = bb.rd_dly;
      loadResponder(bb);
      sb.push_back(toExp(bb));
      sb.push_back(toExp(bb));
      req_dwaddr = bb.addr;
      req_mask = bb.mask;
      req_verify = 1'b0;
      req_valid = 1'b1;
      viol = 0;
      for (int i = 0; i < 200 && !rsp_valid; i++) begin
         @(negedge clk);
         if (req_ready && (cfg_mgmt_rd_en || cfg_mgmt_wr_en || rsp_valid)) viol++;
      end
      checkOutput("b2b_first_rsp", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      checkOutput("b2b_gap_ready", 32'({req_ready, cfg_mgmt_rd_en}), 32'b10);
      @(negedge clk);
      checkOutput("b2b_second_rd", 32'({req_ready, cfg_mgmt_rd_en}), 32'b01);
      req_valid = 1'b0;
      waitRsp("b2b_second", rsp_c);
      checkOutput("b2b_ready_busy", 32'(viol), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      checkOutput("rd_wr_overlap", 32'(overlap), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
